// File: rtl/arm_pkg.sv
// ============================================================================
// arm_pkg: shared constants and types for the IF/ID pipeline stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package arm_pkg;

    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    // Encodings double as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ifid_state_t;

    function automatic logic [1:0] state_count(input ifid_state_t s);
        return (s == TWO) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/flopenr.sv
// ============================================================================
// flopenr: enabled register with asynchronous active-high reset to zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module flopenr #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_id_skid_buffer.sv
// ============================================================================
// if_id_skid_buffer: IF/ID stage with a 2-entry skid buffer and registered
// upstream ready, so fetch never sees a combinational path from decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_id_skid_buffer
    import arm_pkg::*;
#(
    parameter int            N   = 64,
    parameter int            IW  = 32,
    parameter logic [IW-1:0] NOP = NOP_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_valid_i,
    input  logic [N-1:0]  if_pc_i,
    input  logic [IW-1:0] if_instr_i,
    output logic          if_ready_o,
    output logic          pc_hold_o,
    input  logic          flush_i,
    output logic          id_valid_o,
    output logic [N-1:0]  id_pc_o,
    output logic [IW-1:0] id_instr_o,
    input  logic          id_ready_i,
    output logic [1:0]    count_o
);

    ifid_state_t   r_state;
    ifid_state_t   w_next_state;
    logic          r_id_valid;
    logic          r_if_ready;
    logic [1:0]    r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_head_en;
    logic          w_skid_en;
    logic          w_head_from_skid;

    logic [N-1:0]  w_head_pc_d;
    logic [IW-1:0] w_head_instr_d;
    logic [N-1:0]  w_head_pc;
    logic [IW-1:0] w_head_instr;
    logic [N-1:0]  w_skid_pc;
    logic [IW-1:0] w_skid_instr;

    assign w_push = if_valid_i & r_if_ready;
    assign w_pop  = r_id_valid & id_ready_i;

    always_comb begin
        w_next_state     = r_state;
        w_head_en        = 1'b0;
        w_skid_en        = 1'b0;
        w_head_from_skid = 1'b0;
        if (flush_i) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_next_state = ONE;
                        w_head_en    = 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop) begin
                        w_next_state = TWO;
                        w_skid_en    = 1'b1;
                    end else if (w_push && w_pop) begin
                        w_head_en    = 1'b1;
                    end else if (w_pop) begin
                        w_next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_next_state     = ONE;
                        w_head_en        = 1'b1;
                        w_head_from_skid = 1'b1;
                    end
                end
                default: w_next_state = EMPTY;
            endcase
        end
    end

    assign w_head_pc_d    = w_head_from_skid ? w_skid_pc    : if_pc_i;
    assign w_head_instr_d = w_head_from_skid ? w_skid_instr : if_instr_i;

    // Handshake outputs are computed from the next state so they stay registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_id_valid <= 1'b0;
            r_if_ready <= 1'b1;
            r_count    <= 2'd0;
        end else begin
            r_state    <= w_next_state;
            r_id_valid <= (w_next_state != EMPTY);
            r_if_ready <= (w_next_state != TWO);
            r_count    <= state_count(w_next_state);
        end
    end

    flopenr #(.N(N)) u_head_pc (
        .clk   (clk),
        .reset (reset),
        .en    (w_head_en),
        .d     (w_head_pc_d),
        .q     (w_head_pc)
    );

    flopenr #(.N(IW)) u_head_instr (
        .clk   (clk),
        .reset (reset),
        .en    (w_head_en),
        .d     (w_head_instr_d),
        .q     (w_head_instr)
    );

    flopenr #(.N(N)) u_skid_pc (
        .clk   (clk),
        .reset (reset),
        .en    (w_skid_en),
        .d     (if_pc_i),
        .q     (w_skid_pc)
    );

    flopenr #(.N(IW)) u_skid_instr (
        .clk   (clk),
        .reset (reset),
        .en    (w_skid_en),
        .d     (if_instr_i),
        .q     (w_skid_instr)
    );

    assign if_ready_o = r_if_ready;
    assign pc_hold_o  = ~r_if_ready;
    assign id_valid_o = r_id_valid;
    assign id_pc_o    = w_head_pc;
    assign id_instr_o = r_id_valid ? w_head_instr : NOP;
    assign count_o    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_buffer.sv
// Directed testbench for if_id_skid_buffer.
`default_nettype none

module tb_if_id_skid_buffer;

    localparam logic [31:0] NOPV = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid_i = 1'b0;
    logic [63:0] if_pc_i = '0;
    logic [31:0] if_instr_i = '0;
    logic        if_ready_o;
    logic        pc_hold_o;
    logic        flush_i = 1'b0;
    logic        id_valid_o;
    logic [63:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_ready_i = 1'b0;
    logic [1:0]  count_o;

    int vectors = 0;
    int miscompares = 0;

    if_id_skid_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_instr_i (if_instr_i),
        .if_ready_o (if_ready_o),
        .pc_hold_o  (pc_hold_o),
        .flush_i    (flush_i),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_instr_o (id_instr_o),
        .id_ready_i (id_ready_i),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        if_valid_i = v; if_pc_i = pc; if_instr_i = ins; id_ready_i = rdy; flush_i = fl;
    endtask

    task automatic test_reset();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();
        vectors++;
        if (id_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", id_valid_o); end
        vectors++;
        if (id_instr_o !== NOPV) begin miscompares++; $display("FAIL reset_instr got %h want %h", id_instr_o, NOPV); end
        vectors++;
        if (if_ready_o !== 1'b1 || pc_hold_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready got rdy=%b hold=%b want 1/0", if_ready_o, pc_hold_o); end
        vectors++;
        if (count_o !== 2'd0 || id_pc_o !== 64'h0) begin miscompares++; $display("FAIL reset_count got cnt=%0d pc=%h want 0/0", count_o, id_pc_o); end
    endtask

    task automatic test_stream();
        logic [63:0] pcs [4] = '{64'h0, 64'h4, 64'h8, 64'hC};
        logic [31:0] ins [4] = '{32'h8B020020, 32'hAA000004, 32'hAA000008, 32'hAA00000C};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pcs[i], ins[i], 1'b1, 1'b0);
            step();
            vectors++;
            if (id_valid_o !== 1'b1 || id_pc_o !== pcs[i] || id_instr_o !== ins[i] || count_o !== 2'd1)
            begin miscompares++; $display("FAIL stream[%0d] got v=%b pc=%h ins=%h cnt=%0d want 1/%h/%h/1", i, id_valid_o, id_pc_o, id_instr_o, count_o, pcs[i], ins[i]); end
        end
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        step();
        vectors++;
        if (id_valid_o !== 1'b0 || count_o !== 2'd0 || id_instr_o !== NOPV || id_pc_o !== 64'hC)
        begin miscompares++; $display("FAIL stream_drain got v=%b cnt=%0d ins=%h pc=%h want 0/0/%h/c", id_valid_o, count_o, id_instr_o, id_pc_o, NOPV); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 64'h10, 32'h11110010, 1'b0, 1'b0);
        step();
        vectors++;
        if (count_o !== 2'd1 || id_pc_o !== 64'h10 || if_ready_o !== 1'b1)
        begin miscompares++; $display("FAIL bp_one got cnt=%0d pc=%h rdy=%b want 1/10/1", count_o, id_pc_o, if_ready_o); end
        drive(1'b1, 64'h14, 32'h11110014, 1'b0, 1'b0);
        step();
        vectors++;
        if (count_o !== 2'd2 || if_ready_o !== 1'b0 || pc_hold_o !== 1'b1 || id_pc_o !== 64'h10 || id_instr_o !== 32'h11110010)
        begin miscompares++; $display("FAIL bp_full got cnt=%0d rdy=%b hold=%b pc=%h ins=%h want 2/0/1/10/11110010", count_o, if_ready_o, pc_hold_o, id_pc_o, id_instr_o); end
        // Fetch keeps offering while full; it must not be taken.
        drive(1'b1, 64'h99, 32'h99999999, 1'b0, 1'b0);
        step();
        vectors++;
        if (count_o !== 2'd2 || id_pc_o !== 64'h10)
        begin miscompares++; $display("FAIL bp_hold got cnt=%0d pc=%h want 2/10", count_o, id_pc_o); end
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        step();
        vectors++;
        if (count_o !== 2'd1 || id_pc_o !== 64'h14 || id_instr_o !== 32'h11110014 || if_ready_o !== 1'b1 || pc_hold_o !== 1'b0)
        begin miscompares++; $display("FAIL bp_pop1 got cnt=%0d pc=%h ins=%h rdy=%b want 1/14/11110014/1", count_o, id_pc_o, id_instr_o, if_ready_o); end
        step();
        vectors++;
        if (count_o !== 2'd0 || id_valid_o !== 1'b0)
        begin miscompares++; $display("FAIL bp_pop2 got cnt=%0d v=%b want 0/0", count_o, id_valid_o); end
    endtask

    task automatic test_flush();
        drive(1'b1, 64'h30, 32'h22220030, 1'b0, 1'b0);
        step();
        drive(1'b1, 64'h34, 32'h22220034, 1'b0, 1'b0);
        step();
        drive(1'b1, 64'h18, 32'h22220018, 1'b0, 1'b1);
        step();
        vectors++;
        if (count_o !== 2'd0 || id_valid_o !== 1'b0 || id_pc_o === 64'h18 || if_ready_o !== 1'b1)
        begin miscompares++; $display("FAIL flush_full got cnt=%0d v=%b pc=%h rdy=%b want 0/0/not18/1", count_o, id_valid_o, id_pc_o, if_ready_o); end
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        step();
        vectors++;
        if (count_o !== 2'd0 || id_pc_o === 64'h18)
        begin miscompares++; $display("FAIL flush_after got cnt=%0d pc=%h want 0/not18", count_o, id_pc_o); end
        // Flush from ONE with an acceptable push pending: push must be dropped.
        drive(1'b1, 64'h40, 32'h22220040, 1'b0, 1'b0);
        step();
        drive(1'b1, 64'h18, 32'h22220018, 1'b0, 1'b1);
        step();
        vectors++;
        if (count_o !== 2'd0 || id_valid_o !== 1'b0 || id_pc_o !== 64'h40 || id_instr_o !== NOPV)
        begin miscompares++; $display("FAIL flush_one got cnt=%0d v=%b pc=%h ins=%h want 0/0/40/%h", count_o, id_valid_o, id_pc_o, id_instr_o, NOPV); end
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_replace();
        drive(1'b1, 64'h50, 32'h33330050, 1'b0, 1'b0);
        step();
        drive(1'b1, 64'h20, 32'h33330020, 1'b1, 1'b0);
        step();
        vectors++;
        if (count_o !== 2'd1 || id_pc_o !== 64'h20 || id_instr_o !== 32'h33330020 || if_ready_o !== 1'b1)
        begin miscompares++; $display("FAIL replace got cnt=%0d pc=%h ins=%h rdy=%b want 1/20/33330020/1", count_o, id_pc_o, id_instr_o, if_ready_o); end
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        step();
        vectors++;
        if (count_o !== 2'd0 || id_valid_o !== 1'b0)
        begin miscompares++; $display("FAIL replace_drain got cnt=%0d v=%b want 0/0", count_o, id_valid_o); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 64'h60, 32'h44440060, 1'b0, 1'b0);
        step();
        drive(1'b1, 64'h64, 32'h44440064, 1'b0, 1'b0);
        step();
        vectors++;
        if (count_o !== 2'd2)
        begin miscompares++; $display("FAIL ar_fill got cnt=%0d want 2", count_o); end
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (count_o !== 2'd0 || id_valid_o !== 1'b0 || id_pc_o !== 64'h0 || id_instr_o !== NOPV || if_ready_o !== 1'b1 || pc_hold_o !== 1'b0)
        begin miscompares++; $display("FAIL ar_immediate got cnt=%0d v=%b pc=%h ins=%h rdy=%b hold=%b want 0/0/0/%h/1/0", count_o, id_valid_o, id_pc_o, id_instr_o, if_ready_o, pc_hold_o, NOPV); end
        #2 reset = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        step();
        vectors++;
        if (count_o !== 2'd0 || id_valid_o !== 1'b0)
        begin miscompares++; $display("FAIL ar_after got cnt=%0d v=%b want 0/0", count_o, id_valid_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_replace();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
